button_conditioner: RTL and testbench
=====================================

# button_conditioner

Multi-button debouncer with press/release edge pulses and hold-to-auto-repeat, clocked on the system clock and advanced by the one-cycle tick from the clock divider. It sits directly downstream of the divider and turns raw board push-buttons into clean single-cycle events for the Sudoku cursor and cell-entry logic. Holding a direction button produces repeated step events.

## Interface
- N_BTN, 5, number of independent buttons
- STABLE_TICKS, 4, consecutive ticks a synchronized input must differ from the debounced level before the level flips (≥1)
- REPEAT_DELAY, 50, ticks from press to first auto-repeat event (≥1)
- REPEAT_RATE, 10, ticks between subsequent auto-repeat events (≥1)

- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- tick  input  1  one-cycle enable pulse from the clock divider; every clk cycle with tick=1 counts as one tick
- btn_raw  input  N_BTN  asynchronous raw button levels, 1 = pressed
- btn_level  output  N_BTN  debounced level, registered
- btn_press  output  N_BTN  one-cycle pulse on debounced 0→1
- btn_release  output  N_BTN  one-cycle pulse on debounced 1→0
- btn_repeat  output  N_BTN  one-cycle pulse on press and on every auto-repeat event

## Operation
- Every bit of btn_raw passes through a 2-FF synchronizer on every clk (not tick-gated); sync value = second stage.
- Per-button debounce counter, width $clog2(STABLE_TICKS+1):
  - On a tick with sync ≠ btn_level: counter+1; when the incremented value equals STABLE_TICKS, btn_level flips and counter clears, all on the same edge.
  - On a tick with sync = btn_level: counter clears.
  - No tick: counter holds.
- btn_press / btn_release registered on the same edge that flips btn_level; high for exactly one clk cycle.
- Per-button repeat FSM, states IDLE, DELAY, REPEAT; counter width $clog2(max(REPEAT_DELAY,REPEAT_RATE)+1):
  - IDLE: on level 0→1 → DELAY, cnt=0, btn_repeat pulses with btn_press.
  - DELAY: each tick cnt+1; when incremented value equals REPEAT_DELAY → btn_repeat pulse, cnt=0, → REPEAT.
  - REPEAT: each tick cnt+1; when incremented value equals REPEAT_RATE → btn_repeat pulse, cnt=0, stay.
  - Level 1→0 from any state → IDLE, cnt=0.
- Buttons are fully independent; no priority or mutual exclusion.

## Timing
- Reset (asynchronous, immediate): synchronizers, btn_level, all pulse outputs, all counters = 0; FSMs = IDLE.
- Latency raw→level: 2 clk synchronizer + STABLE_TICKS qualifying ticks; level flips on the edge of the STABLE_TICKS-th tick.
- A single disagreeing-then-agreeing tick restarts debounce from zero.
- Release and repeat expiry on the same tick: release wins, no btn_repeat pulse.
- Auto-repeat ticks occur at press+REPEAT_DELAY, then every REPEAT_RATE ticks, measured in ticks counted after the press edge.
- Button held through reset deassertion: treated as new press after STABLE_TICKS ticks (press and repeat pulses emitted).
- tick held high continuously: each cycle counts; STABLE_TICKS=1 gives level update 1 cycle after sync change.
- Pulse outputs never exceed one cycle; no two press pulses without an intervening release.

## Test plan
(N_BTN=2, STABLE_TICKS=4, REPEAT_DELAY=6, REPEAT_RATE=3, tick every 4 clk.)
- Clean press: btn_raw[0] 0→1 and held -> btn_level[0] rises on 4th tick after sync sees 1; btn_press[0] and btn_repeat[0] high exactly one cycle on that edge; bit 1 outputs stay 0.
- Bounce: btn_raw[0] toggled every 2 ticks for 12 ticks, then held 1 -> no press during bouncing; exactly one btn_press 4 ticks after final stable edge.
- Hold: press held 20 ticks -> btn_repeat pulses at press tick +0, +6, +9, +12, +15, +18; nothing else.
- Release: release at press+9 ticks raw, stable -> btn_release after 4 ticks, level 0, no further btn_repeat; variant where level falls on the tick a repeat would fire -> release pulse only.
- Independence: btn_raw[1] pressed 2 ticks after btn_raw[0] -> each button's press/repeat schedule offset by 2 ticks, no cross-talk.
- Async reset mid-hold: rst_n low between clk edges while btn_level[0]=1 -> all outputs 0 immediately; deassert with button held -> btn_press[0] after 4 ticks (+2 clk synchronizer).

Source files
------------

// File: rtl/button_conditioner.sv
// button_conditioner: synchronizes, debounces and edge-detects raw push-buttons, and
// turns a held button into a press pulse followed by tick-paced auto-repeat pulses.

// One button: debounce counter, registered edge pulses and the repeat FSM.
module btn_lane #(
  parameter int STABLE_TICKS = 4,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic sync,
  output logic level,
  output logic press,
  output logic rel,
  output logic rep
);

  localparam int DW   = $clog2(STABLE_TICKS + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [DW-1:0] DB_LAST   = DW'(STABLE_TICKS);
  localparam logic [RW-1:0] DLY_LAST  = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] RATE_LAST = RW'(REPEAT_RATE);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_t;

  // ---------------- debounce ----------------
  logic [DW-1:0] db_cnt, db_inc;
  logic          differ, flip, rise, fall;

  assign differ = tick && (sync != level);
  assign db_inc = db_cnt + DW'(1);
  assign flip   = differ && (db_inc == DB_LAST);
  assign rise   = flip && !level;
  assign fall   = flip && level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt <= '0;
      level  <= 1'b0;
      press  <= 1'b0;
      rel    <= 1'b0;
    end else begin
      press <= rise;
      rel   <= fall;
      // an agreeing tick throws away any partial run of disagreement
      if (flip || (tick && !differ)) db_cnt <= '0;
      else if (differ)               db_cnt <= db_inc;
      if (flip) level <= ~level;
    end
  end

  // ---------------- auto-repeat ----------------
  rep_state_t    state, state_nxt;
  logic [RW-1:0] rcnt, rcnt_nxt, rcnt_inc;
  logic          rep_nxt;

  assign rcnt_inc = rcnt + RW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rcnt  <= '0;
      rep   <= 1'b0;
    end else begin
      state <= state_nxt;
      rcnt  <= rcnt_nxt;
      rep   <= rep_nxt;
    end
  end

  // release is checked first so a release landing on an expiry tick suppresses the pulse
  always_comb begin
    state_nxt = state;
    rcnt_nxt  = rcnt;
    rep_nxt   = 1'b0;
    if (fall) begin
      state_nxt = IDLE;
      rcnt_nxt  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            state_nxt = DELAY;
            rcnt_nxt  = '0;
            rep_nxt   = 1'b1;
          end
        end
        DELAY: begin
          if (tick) begin
            if (rcnt_inc == DLY_LAST) begin
              state_nxt = REPEAT;
              rcnt_nxt  = '0;
              rep_nxt   = 1'b1;
            end else begin
              rcnt_nxt = rcnt_inc;
            end
          end
        end
        REPEAT: begin
          if (tick) begin
            if (rcnt_inc == RATE_LAST) begin
              rcnt_nxt = '0;
              rep_nxt  = 1'b1;
            end else begin
              rcnt_nxt = rcnt_inc;
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          rcnt_nxt  = '0;
        end
      endcase
    end
  end

endmodule

module button_conditioner #(
  parameter int N_BTN        = 5,
  parameter int STABLE_TICKS = 4,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat
);

  // two-stage synchronizer, free-running on clk; stage 1 feeds the lanes
  logic [1:0][N_BTN-1:0] sync_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_pipe <= '0;
    else        sync_pipe <= {sync_pipe[0], btn_raw};
  end

  genvar i;
  generate
    for (i = 0; i < N_BTN; i++) begin : g_lane
      btn_lane #(
        .STABLE_TICKS (STABLE_TICKS),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
      ) u_lane (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick),
        .sync  (sync_pipe[1][i]),
        .level (btn_level[i]),
        .press (btn_press[i]),
        .rel   (btn_release[i]),
        .rep   (btn_repeat[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random traffic, each cycle checked
// against a model that decides flips from the recent tick-sample history and repeats by arithmetic.
module tb_button_conditioner;
  localparam int N  = 2;
  localparam int ST = 4;
  localparam int RD = 6;
  localparam int RR = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         tick = 1'b0;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] btn_level, btn_press, btn_release, btn_repeat;

  int checks = 0;
  int errors = 0;

  // reference model
  logic [N-1:0] raw_hist[$];
  logic [N-1:0] samp[$];
  logic [N-1:0] m_level, m_press, m_release, m_repeat;
  int flip_tick[N];
  int press_tick[N];

  // observed-event bookkeeping for the scenario checks
  int cyc = 0;
  int tcount = 0;
  int n_press[N];
  int n_rep[N];
  int n_rel[N];
  int rel_rep = 0;
  int press_at[N];

  button_conditioner #(
    .N_BTN(N), .STABLE_TICKS(ST), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_press(btn_press),
    .btn_release(btn_release), .btn_repeat(btn_repeat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    raw_hist.delete();
    raw_hist.push_back('0);
    raw_hist.push_back('0);
    samp.delete();
    m_level = '0; m_press = '0; m_release = '0; m_repeat = '0;
    for (int b = 0; b < N; b++) begin
      flip_tick[b] = 0;
      press_tick[b] = 0;
    end
  endtask

  // level flips once the last ST tick samples since the previous flip all disagree;
  // repeats land at press+0 and press+RD+k*RR ticks while the level stays high
  task automatic model_edge();
    logic [N-1:0] s;
    int t, d;
    bit all_diff;
    raw_hist.push_back(btn_raw);
    s = raw_hist[raw_hist.size()-3];
    m_press = '0; m_release = '0; m_repeat = '0;
    if (tick) begin
      samp.push_back(s);
      t = samp.size();
      for (int b = 0; b < N; b++) begin
        all_diff = (t - flip_tick[b]) >= ST;
        for (int k = 0; k < ST && all_diff; k++)
          if (samp[t-1-k][b] == m_level[b]) all_diff = 0;
        if (all_diff) begin
          flip_tick[b] = t;
          m_level[b] = ~m_level[b];
          if (m_level[b]) begin
            m_press[b] = 1'b1;
            m_repeat[b] = 1'b1;
            press_tick[b] = t;
          end else begin
            m_release[b] = 1'b1;
          end
        end else if (m_level[b]) begin
          d = t - press_tick[b];
          if (d >= RD && ((d - RD) % RR) == 0) m_repeat[b] = 1'b1;
        end
      end
    end
    if (raw_hist.size() > 8) void'(raw_hist.pop_front());
  endtask

  task automatic step(input logic [N-1:0] raw, input logic tk);
    btn_raw = raw;
    tick = tk;
    @(posedge clk);
    if (rst_n) model_edge();
    else model_reset();
    #1;
    if (tk) tcount++;
    for (int b = 0; b < N; b++) begin
      if (btn_press[b]) begin n_press[b]++; press_at[b] = tcount; end
      if (btn_repeat[b]) n_rep[b]++;
      if (btn_release[b]) n_rel[b]++;
      if (btn_release[b] && btn_repeat[b]) rel_rep++;
    end
    chk("level", btn_level, m_level);
    chk("press", btn_press, m_press);
    chk("release", btn_release, m_release);
    chk("repeat", btn_repeat, m_repeat);
    cyc++;
  endtask

  task automatic hold(input logic [N-1:0] raw, input int nticks);
    int seen;
    logic tk;
    seen = 0;
    while (seen < nticks) begin
      tk = (cyc % 4) == 3;
      step(raw, tk);
      if (tk) seen++;
    end
  endtask

  task automatic wait_press0(input logic [N-1:0] raw);
    int n;
    bit found;
    logic tk;
    n = 0;
    found = 0;
    while (!found && n < 200) begin
      tk = (cyc % 4) == 3;
      step(raw, tk);
      found = m_press[0];
      n++;
    end
    chk_int("press_wait_bound", int'(found), 1);
  endtask

  task automatic clr_counts();
    for (int b = 0; b < N; b++) begin
      n_press[b] = 0; n_rep[b] = 0; n_rel[b] = 0; press_at[b] = -1;
    end
    rel_rep = 0;
  endtask

  initial begin
    logic [N-1:0] r;
    logic tk;
    bit cont;
    model_reset();
    clr_counts();

    // async reset at power-up
    #1 rst_n = 1'b0;
    #1;
    chk("rst_level", btn_level, '0);
    chk("rst_press", btn_press, '0);
    chk("rst_release", btn_release, '0);
    chk("rst_repeat", btn_repeat, '0);
    for (int i = 0; i < 3; i++) step('0, 1'b0);
    rst_n = 1'b1;
    hold('0, 3);

    // clean press held 24 ticks, then release
    clr_counts();
    hold(2'b01, 24);
    chk_int("clean_press_cnt", n_press[0], 1);
    chk_int("clean_repeat_cnt", n_rep[0], 6);
    chk_int("clean_btn1_quiet", n_press[1] + n_rep[1] + n_rel[1], 0);
    hold(2'b00, 8);
    chk_int("clean_release_cnt", n_rel[0], 1);

    // release raw at press+9: repeats at +0,+6,+9,+12
    clr_counts();
    wait_press0(2'b01);
    hold(2'b01, 9);
    hold(2'b00, 10);
    chk_int("relA_repeat_cnt", n_rep[0], 4);
    chk_int("relA_release_cnt", n_rel[0], 1);

    // level falls exactly on the +9 repeat tick: release wins
    clr_counts();
    wait_press0(2'b01);
    hold(2'b01, 5);
    hold(2'b00, 10);
    chk_int("relB_repeat_cnt", n_rep[0], 2);
    chk_int("relB_release_cnt", n_rel[0], 1);
    chk_int("relB_release_with_repeat", rel_rep, 0);

    // bounce every 2 ticks for 12 ticks, then settle high
    clr_counts();
    for (int i = 0; i < 3; i++) begin
      hold(2'b01, 2);
      hold(2'b00, 2);
    end
    chk_int("bounce_no_press", n_press[0], 0);
    hold(2'b01, 8);
    chk_int("bounce_one_press", n_press[0], 1);
    hold(2'b00, 8);

    // independence: button 1 two ticks behind button 0
    clr_counts();
    hold(2'b01, 2);
    hold(2'b11, 26);
    chk_int("indep_press0", n_press[0], 1);
    chk_int("indep_press1", n_press[1], 1);
    chk_int("indep_offset", press_at[1] - press_at[0], 2);
    chk_int("indep_repeat0", n_rep[0], 8);
    chk_int("indep_repeat1", n_rep[1], 7);

    // async reset mid-hold, between clock edges
    chk("pre_reset_level", btn_level, 2'b11);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_level", btn_level, '0);
    chk("midrst_press", btn_press, '0);
    chk("midrst_release", btn_release, '0);
    chk("midrst_repeat", btn_repeat, '0);
    for (int i = 0; i < 3; i++) step(2'b11, 1'b0);
    rst_n = 1'b1;
    clr_counts();
    hold(2'b11, 8);
    chk_int("post_rst_press0", n_press[0], 1);
    chk_int("post_rst_press1", n_press[1], 1);
    hold(2'b00, 8);

    // random traffic, alternating sparse and continuous tick segments
    r = '0;
    cont = 0;
    for (int i = 0; i < 1500; i++) begin
      if ((i % 250) == 0) cont = ($urandom_range(0, 2) == 0);
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 23) == 0) r[b] = ~r[b];
      tk = cont ? 1'b1 : ($urandom_range(0, 2) == 0);
      step(r, tk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
